// File: rtl/stream_mux2.sv
// Two-input valid/ready stream merger with a one-word registered output slot.
// Tie arbitration is fixed priority (A wins) unless STREAM_MUX_RR_EN selects round-robin.
module stream_mux2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;
    logic   slot_free;
    logic   grant_a;
    logic   grant_b;

`ifdef STREAM_MUX_RR_EN
    logic prefer_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Holding rst_n in the free term keeps both readies low while reset is asserted.
    always_comb begin
        slot_free  = rst_n && ((state == EMPTY) || out_ready);
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        next_state = state;

        if (slot_free) begin
            if (a_valid && b_valid) begin
`ifdef STREAM_MUX_RR_EN
                grant_a = !prefer_b;
                grant_b = prefer_b;
`else
                grant_a = 1'b1;
`endif
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end

        if (grant_a || grant_b) begin
            next_state = FULL;
        end else if ((state == FULL) && out_ready) begin
            next_state = EMPTY;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign out_valid = (state == FULL);

    // Payload and source only change on an accepted word; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= 1'b0;
        end else if (grant_a) begin
            out_data <= a_data;
            out_sel  <= 1'b0;
        end else if (grant_b) begin
            out_data <= b_data;
            out_sel  <= 1'b1;
        end
    end

`ifdef STREAM_MUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_b <= 1'b0;
        end else if (grant_a) begin
            prefer_b <= 1'b1;
        end else if (grant_b) begin
            prefer_b <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux2.sv
// Scoreboard bench for stream_mux2: a reference model pushes expected words on acceptance,
// a separate monitor pops and compares them as the DUT presents its output.
module tb_stream_mux2;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;

    int vec_count = 0;
    int miscompares = 0;

    logic [WIDTH:0]   exp_q[$];
    bit               m_full = 1'b0;
    bit               m_pref_b = 1'b0;
    bit               exp_a;
    bit               exp_b;
    logic [WIDTH-1:0] last_data = '0;
    logic             last_sel = 1'b0;

    stream_mux2 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [WIDTH-1:0] ad,
                                 input logic bv, input logic [WIDTH-1:0] bd,
                                 input logic ordy);
        @(posedge clk);
        #1;
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
    endtask

    // Asynchronous reset pulse placed between clock edges; the model is cleared alongside.
    task automatic resetPulse();
        #1;
        rst_n     = 1'b0;
        m_full    = 1'b0;
        m_pref_b  = 1'b0;
        last_data = '0;
        last_sel  = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_sel", out_sel, 0);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_b_ready", b_ready, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: predicts readies and out_valid, pushes each accepted word.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", out_valid, m_full);
            exp_a = 1'b0;
            exp_b = 1'b0;
            if (!m_full || out_ready) begin
                if (a_valid && b_valid) begin
`ifdef STREAM_MUX_RR_EN
                    if (m_pref_b) exp_b = 1'b1;
                    else          exp_a = 1'b1;
`else
                    exp_a = 1'b1;
`endif
                end else begin
                    exp_a = a_valid;
                    exp_b = b_valid;
                end
            end
            checkOutput("a_ready", a_ready, exp_a);
            checkOutput("b_ready", b_ready, exp_b);
            checkOutput("ready_onehot", a_ready & b_ready, 0);
            if (exp_a) begin
                exp_q.push_back({1'b0, a_data});
                m_pref_b = 1'b1;
            end else if (exp_b) begin
                exp_q.push_back({1'b1, b_data});
                m_pref_b = 1'b0;
            end
            m_full = exp_a || exp_b || (m_full && !out_ready);
        end
    end

    // Monitor: compares the presented word, pops on consumption, checks hold when empty.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vec_count++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_word: got %0h sel %0b, expected none at t=%0t",
                             out_data, out_sel, $time);
                end else begin
                    checkOutput("out_data", out_data, exp_q[0][WIDTH-1:0]);
                    checkOutput("out_sel", out_sel, exp_q[0][WIDTH]);
                    if (out_ready) begin
                        last_data = exp_q[0][WIDTH-1:0];
                        last_sel  = exp_q[0][WIDTH];
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                checkOutput("hold_data", out_data, last_data);
                checkOutput("hold_sel", out_sel, last_sel);
            end
        end
    end

    initial begin
        logic [3:0] tie_b_ready;
`ifdef STREAM_MUX_RR_EN
        tie_b_ready = 4'b1010;
`else
        tie_b_ready = 4'b0000;
`endif
        // Reset held with A offering a word: nothing may be accepted.
        a_valid = 1'b1;
        a_data  = 16'hDEAD;
        #3;
        checkOutput("init_out_valid", out_valid, 0);
        checkOutput("init_out_data", out_data, 0);
        checkOutput("init_a_ready", a_ready, 0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst_n   = 1'b1;

        // Single A word, latency one.
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1);
        #1 checkOutput("lat_a_ready", a_ready, 1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        #1;
        checkOutput("lat_out_valid", out_valid, 1);
        checkOutput("lat_out_data", out_data, 16'h1234);
        checkOutput("lat_out_sel", out_sel, 0);

        // Stall while full, then same-cycle drain and refill.
        applyStimulus(1'b1, 16'h00FF, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0101, 1'b0, 16'h0000, 1'b0);
            #1;
            checkOutput("stall_a_ready", a_ready, 0);
            checkOutput("stall_out_data", out_data, 16'h00FF);
        end
        applyStimulus(1'b1, 16'h0101, 1'b0, 16'h0000, 1'b1);
        #1 checkOutput("refill_a_ready", a_ready, 1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        #1 checkOutput("refill_out_data", out_data, 16'h0101);

        // Drain to empty: data holds.
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        #1;
        checkOutput("empty_out_valid", out_valid, 0);
        checkOutput("empty_out_data", out_data, 16'h0101);

        // Fill from B, stall with a tie pending, then reset mid-cycle.
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1);
        applyStimulus(1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0);
        resetPulse();

        // Four tie cycles after reset: A wins the first tie in both builds.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b1);
            #1 checkOutput("tie_b_ready", b_ready, tie_b_ready[i]);
        end

        // Randomised traffic.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 3) != 0));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        @(negedge clk);
        #1;
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        checkOutput("drain_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
